// File: rtl/bids22_cmd_issuer.sv
// Command issuer in front of the BIDS22 bid controller. Host commands are buffered in a FIFO and
// issued one at a time on C_op/C_data/C_start. Each one gets a response with its result code.
module bids22_cmd_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic [3:0]  C_op,
  output logic [31:0] C_data,
  output logic        C_start,
  input  logic        ready,
  input  logic [2:0]  err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_op,
  output logic [2:0]  rsp_err,
  output logic [15:0] issued_count,
  output logic [15:0] error_count,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  localparam logic [3:0]  OP_NOP      = 4'd0;
  localparam logic [3:0]  OP_LAST     = 4'd10;
  localparam logic [2:0]  ERR_TIMEOUT = 3'b111;
  localparam logic [2:0]  ERR_ILLEGAL = 3'b110;
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  state_t        state, state_d;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0] wait_cnt, wait_cnt_d;
  logic          push, pop, empty, full_d;
  logic [3:0]    c_op_d, rsp_op_d;
  logic [31:0]   c_data_d;
  logic          rsp_valid_d;
  logic [2:0]    rsp_err_d;
  logic [15:0]   issued_d, error_d;

  assign push    = cmd_valid && cmd_ready;
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  // The strobe must coincide with the cycle the controller is seen ready.
  assign C_start = (state == ISSUE) && ready;

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{op: cmd_op, data: cmd_data};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    c_op_d      = C_op;
    c_data_d    = C_data;
    rsp_valid_d = rsp_valid;
    rsp_op_d    = rsp_op;
    rsp_err_d   = rsp_err;
    issued_d    = issued_count;
    error_d     = error_count;
    wait_cnt_d  = wait_cnt;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.op == OP_NOP) begin
            rsp_valid_d = 1'b1;
            rsp_op_d    = head.op;
            rsp_err_d   = 3'b000;
            state_d     = RESP;
          end else if (head.op <= OP_LAST) begin
            c_op_d   = head.op;
            c_data_d = head.data;
            state_d  = ISSUE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_op_d    = head.op;
            rsp_err_d   = ERR_ILLEGAL;
            state_d     = RESP;
          end
        end
      end
      ISSUE: begin
        if (ready) begin
          wait_cnt_d = '0;
          if (issued_count != CNT_MAX) begin
            issued_d = issued_count + 16'd1;
          end
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (ready) begin
          rsp_valid_d = 1'b1;
          rsp_op_d    = C_op;
          rsp_err_d   = err;
          state_d     = RESP;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_op_d    = C_op;
          rsp_err_d   = ERR_TIMEOUT;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if ((rsp_err != 3'b000) && (error_count != CNT_MAX)) begin
            error_d = error_count + 16'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr + PW'(push);
    rd_ptr_d = rd_ptr + PW'(pop);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wait_cnt     <= '0;
      C_op         <= 4'd0;
      C_data       <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_op       <= 4'd0;
      rsp_err      <= 3'b000;
      issued_count <= 16'd0;
      error_count  <= 16'd0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      wr_ptr       <= wr_ptr_d;
      rd_ptr       <= rd_ptr_d;
      wait_cnt     <= wait_cnt_d;
      C_op         <= c_op_d;
      C_data       <= c_data_d;
      rsp_valid    <= rsp_valid_d;
      rsp_op       <= rsp_op_d;
      rsp_err      <= rsp_err_d;
      issued_count <= issued_d;
      error_count  <= error_d;
      cmd_ready    <= !full_d;
      busy         <= (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
    end
  end

endmodule

// File: tb/tb_bids22_cmd_issuer.sv
// Directed bench for bids22_cmd_issuer: issue path, FIFO backpressure, timeout, NOP/illegal
// opcodes, response backpressure and mid-operation reset.
module tb_bids22_cmd_issuer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ready;
  logic [2:0]  err;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_op;
  logic [2:0]  rsp_err;
  logic [15:0] issued_count;
  logic [15:0] error_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bids22_cmd_issuer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .C_op(C_op), .C_data(C_data), .C_start(C_start), .ready(ready), .err(err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .issued_count(issued_count), .error_count(error_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_c_op"},      32'(C_op), 32'd0);
    chk({tag, "_c_data"},    C_data, 32'd0);
    chk({tag, "_c_start"},   32'(C_start), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_op"},    32'(rsp_op), 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_issued"},    32'(issued_count), 32'd0);
    chk({tag, "_errors"},    32'(error_count), 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_data = 32'd0;
    ready = 1'b0; err = 3'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    tick(); reset = 1'b0; smp();
    chk_reset_state("por");

    // Single Unlock with controller ready
    tick(); cmd_valid = 1'b1; cmd_op = 4'd1; cmd_data = 32'h0000_1234;
    ready = 1'b1; rsp_ready = 1'b1; err = 3'd0;
    tick(); cmd_valid = 1'b0;
    tick(); smp();
    chk("t1_start", 32'(C_start), 32'd1);
    chk("t1_c_op", 32'(C_op), 32'd1);
    chk("t1_c_data", C_data, 32'h0000_1234);
    tick(); smp();
    chk("t1_start_once", 32'(C_start), 32'd0);
    chk("t1_issued", 32'(issued_count), 32'd1);
    tick(); smp();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_op", 32'(rsp_op), 32'd1);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    tick(); smp();
    chk("t1_rsp_done", 32'(rsp_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // Fill with ready low: first command is popped into ISSUE, four more fill the FIFO
    tick(); ready = 1'b0; cmd_valid = 1'b1; cmd_op = 4'd3; cmd_data = 32'hA0; smp();
    chk("t2_ready_0", 32'(cmd_ready), 32'd1);
    for (int i = 1; i < 5; i++) begin
      tick(); cmd_op = 4'(3 + i); cmd_data = 32'hA0 + 32'(i); smp();
      chk("t2_ready_fill", 32'(cmd_ready), 32'd1);
      chk("t2_no_start", 32'(C_start), 32'd0);
    end
    tick(); cmd_op = 4'd8; cmd_data = 32'hA5; smp();
    chk("t2_full", 32'(cmd_ready), 32'd0);
    chk("t2_no_start_full", 32'(C_start), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_head_latched", 32'(C_op), 32'd3);
    tick(); cmd_valid = 1'b0; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("t2_drain_start", 32'(C_start), 32'd1);
      chk("t2_drain_op", 32'(C_op), 32'(3 + i));
      chk("t2_drain_data", C_data, 32'hA0 + 32'(i));
      tick(); smp();
      chk("t2_wait_nostart", 32'(C_start), 32'd0);
      tick(); smp();
      chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t2_rsp_op", 32'(rsp_op), 32'(3 + i));
      tick(); smp();
      chk("t2_rsp_clear", 32'(rsp_valid), 32'd0);
      tick();
    end
    smp();
    chk("t2_issued", 32'(issued_count), 32'd6);
    chk("t2_no_sixth", 32'(C_start), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_cmd_ready", 32'(cmd_ready), 32'd1);

    // SetTimer with no completion: timeout after 64 waiting cycles
    tick(); cmd_valid = 1'b1; cmd_op = 4'd7; cmd_data = 32'h40; ready = 1'b1;
    tick(); cmd_valid = 1'b0;
    tick(); smp();
    chk("t3_start", 32'(C_start), 32'd1);
    chk("t3_c_op", 32'(C_op), 32'd7);
    tick(); ready = 1'b0;
    for (int k = 0; k < 64; k++) begin
      smp();
      chk("t3_waiting", 32'(rsp_valid), 32'd0);
      tick();
    end
    smp();
    chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3_timeout", 32'(rsp_err), 32'd7);
    chk("t3_rsp_op", 32'(rsp_op), 32'd7);
    chk("t3_issued", 32'(issued_count), 32'd7);
    tick(); smp();
    chk("t3_err_count", 32'(error_count), 32'd1);
    chk("t3_rsp_clear", 32'(rsp_valid), 32'd0);

    // Same, but ready arrives in the last waiting cycle: completion wins
    tick(); cmd_valid = 1'b1; cmd_op = 4'd7; cmd_data = 32'h41; ready = 1'b1;
    tick(); cmd_valid = 1'b0;
    tick(); smp();
    chk("t3b_start", 32'(C_start), 32'd1);
    tick(); ready = 1'b0;
    for (int k = 0; k < 63; k++) begin
      smp();
      chk("t3b_waiting", 32'(rsp_valid), 32'd0);
      tick();
    end
    ready = 1'b1; err = 3'b011; smp();
    chk("t3b_no_restart", 32'(C_start), 32'd0);
    chk("t3b_not_yet", 32'(rsp_valid), 32'd0);
    tick(); ready = 1'b0; err = 3'd0; smp();
    chk("t3b_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3b_rsp_err", 32'(rsp_err), 32'd3);
    chk("t3b_issued", 32'(issued_count), 32'd8);
    tick(); smp();
    chk("t3b_err_count", 32'(error_count), 32'd2);

    // NoOperation then illegal opcode 4'hC: local responses, no strobe
    tick(); cmd_valid = 1'b1; cmd_op = 4'd0; cmd_data = 32'd0;
    tick(); cmd_op = 4'hC;
    tick(); cmd_valid = 1'b0; smp();
    chk("t4_nop_valid", 32'(rsp_valid), 32'd1);
    chk("t4_nop_op", 32'(rsp_op), 32'd0);
    chk("t4_nop_err", 32'(rsp_err), 32'd0);
    chk("t4_nop_nostart", 32'(C_start), 32'd0);
    tick(); smp();
    chk("t4_gap", 32'(rsp_valid), 32'd0);
    tick(); smp();
    chk("t4_ill_valid", 32'(rsp_valid), 32'd1);
    chk("t4_ill_op", 32'(rsp_op), 32'hC);
    chk("t4_ill_err", 32'(rsp_err), 32'd6);
    chk("t4_ill_nostart", 32'(C_start), 32'd0);
    tick(); smp();
    chk("t4_err_count", 32'(error_count), 32'd3);
    chk("t4_issued", 32'(issued_count), 32'd8);
    chk("t4_c_op_kept", 32'(C_op), 32'd7);
    chk("t4_busy", 32'(busy), 32'd0);

    // BidCharge fails with err=2 while the host stalls the response
    tick(); rsp_ready = 1'b0; ready = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd8; cmd_data = 32'h55;
    tick(); cmd_op = 4'd9; cmd_data = 32'h66;
    tick(); cmd_valid = 1'b0; err = 3'b010; smp();
    chk("t5_start", 32'(C_start), 32'd1);
    chk("t5_c_op", 32'(C_op), 32'd8);
    chk("t5_c_data", C_data, 32'h55);
    tick(); smp();
    chk("t5_wait_nostart", 32'(C_start), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick(); smp();
      chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_op", 32'(rsp_op), 32'd8);
      chk("t5_hold_err", 32'(rsp_err), 32'd2);
      chk("t5_hold_nostart", 32'(C_start), 32'd0);
      chk("t5_hold_issued", 32'(issued_count), 32'd9);
      chk("t5_hold_errcnt", 32'(error_count), 32'd3);
    end
    tick(); rsp_ready = 1'b1; smp();
    chk("t5_release_valid", 32'(rsp_valid), 32'd1);
    tick(); err = 3'd0; smp();
    chk("t5_rsp_clear", 32'(rsp_valid), 32'd0);
    chk("t5_err_once", 32'(error_count), 32'd4);
    tick(); smp();
    chk("t5_next_start", 32'(C_start), 32'd1);
    chk("t5_next_op", 32'(C_op), 32'd9);
    chk("t5_next_data", C_data, 32'h66);

    // Reset while waiting on the controller with two commands queued
    tick(); ready = 1'b0; cmd_valid = 1'b1; cmd_op = 4'd1; cmd_data = 32'd1; smp();
    chk("t6_issued", 32'(issued_count), 32'd10);
    tick(); cmd_op = 4'd2; cmd_data = 32'd2;
    tick(); cmd_valid = 1'b0; smp();
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_pending", 32'(rsp_valid), 32'd0);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; smp();
    chk_reset_state("t6_rst");
    for (int k = 0; k < 4; k++) begin
      tick(); ready = 1'b1; rsp_ready = 1'b1; smp();
      chk("t6_no_start", 32'(C_start), 32'd0);
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
      chk("t6_idle", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
